instr_sequencer: RTL and testbench

- Fetch/issue sequencer placed in front of the processor's instruction controller.
- Holds the program counter and reads 12-bit instructions from a 16-entry instruction memory, or takes one instruction from the board switches.
- Hands each instruction to the controller through a valid/ready handshake, then waits for the datapath's completion pulse before advancing.
- Supports single-step (button) and free-run (switch) modes, halt detection, a completion watchdog and a retired-instruction counter.

---
 rtl/instr_sequencer.sv | 169 ++++++++++++++++
 tb/tb_instr_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Fetch/issue sequencer: walks a 16-entry instruction memory (or takes one switch word),
// hands each instruction over valid/ready, and waits for the datapath's done pulse.
module instr_sequencer #(
  parameter int IW           = 12,
  parameter int AW           = 4,
  parameter int DONE_TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          step_btn,
  input  logic          run_en,
  input  logic          ext_sel,
  input  logic [IW-1:0] ext_instr,
  output logic [AW-1:0] imem_addr,
  input  logic [IW-1:0] imem_data,
  output logic [IW-1:0] instr_out,
  output logic          instr_valid,
  input  logic          instr_ready,
  input  logic          exec_done,
  output logic [AW-1:0] pc,
  output logic          halted,
  output logic          wd_err,
  output logic [7:0]    retired
);

  // state     | meaning
  // IDLE      | waiting for run_en or step_btn
  // FETCH     | decode imem_data at pc
  // ISSUE     | instr_valid high until controller accepts
  // WAIT_DONE | waiting for exec_done, watchdog counting
  // HALT      | halt opcode or watchdog; step with run_en=0 restarts at pc 0
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_WAIT_DONE, S_HALT
  } state_t;

  localparam logic [7:0] TMO_MAX = 8'(DONE_TIMEOUT);

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [IW-1:0] instr_q, instr_d;
  logic          valid_q, valid_d;
  logic          halted_q, halted_d;
  logic          wd_err_q, wd_err_d;
  logic [7:0]    retired_q, retired_d;
  logic [7:0]    tmo_q, tmo_d;
  logic          from_ext_q, from_ext_d;

  logic [AW-1:0] pc_inc;
  logic [7:0]    ret_inc;
  logic [7:0]    tmo_inc;
  logic [2:0]    opcode;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    halted_d   = halted_q;
    wd_err_d   = wd_err_q;
    retired_d  = retired_q;
    tmo_d      = tmo_q;
    from_ext_d = from_ext_q;

    pc_inc  = pc_q + 1'b1;
    ret_inc = (retired_q == 8'hFF) ? retired_q : retired_q + 8'd1;
    tmo_inc = tmo_q + 8'd1;
    opcode  = imem_data[IW-1:IW-3];

    case (state_q)
      S_IDLE: begin
        if (run_en) begin
          state_d = S_FETCH;
        end else if (step_btn) begin
          if (ext_sel) begin
            instr_d    = ext_instr;
            from_ext_d = 1'b1;
            valid_d    = 1'b1;
            state_d    = S_ISSUE;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        case (opcode)
          3'b111: begin
            halted_d = 1'b1;
            state_d  = S_HALT;
          end
          3'b010, 3'b011, 3'b100: begin
            pc_d      = pc_inc;
            retired_d = ret_inc;
            state_d   = run_en ? S_FETCH : S_IDLE;
          end
          default: begin
            instr_d    = imem_data;
            from_ext_d = 1'b0;
            valid_d    = 1'b1;
            state_d    = S_ISSUE;
          end
        endcase
      end
      S_ISSUE: begin
        if (instr_ready) begin
          valid_d = 1'b0;
          tmo_d   = 8'd0;
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        // done takes precedence over a timeout landing on the same cycle
        if (exec_done) begin
          if (!from_ext_q) pc_d = pc_inc;
          retired_d = ret_inc;
          state_d   = run_en ? S_FETCH : S_IDLE;
        end else begin
          tmo_d = tmo_inc;
          if (tmo_inc == TMO_MAX) begin
            wd_err_d = 1'b1;
            halted_d = 1'b1;
            state_d  = S_HALT;
          end
        end
      end
      S_HALT: begin
        if (step_btn && !run_en) begin
          pc_d     = '0;
          wd_err_d = 1'b0;
          halted_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      instr_q    <= '0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
      wd_err_q   <= 1'b0;
      retired_q  <= 8'd0;
      tmo_q      <= 8'd0;
      from_ext_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      halted_q   <= halted_d;
      wd_err_q   <= wd_err_d;
      retired_q  <= retired_d;
      tmo_q      <= tmo_d;
      from_ext_q <= from_ext_d;
    end
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr_out   = instr_q;
  assign instr_valid = valid_q;
  assign halted      = halted_q;
  assign wd_err      = wd_err_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: inputs change on the falling edge, outputs are
// checked on the falling edge after each rising edge.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        step_btn, run_en, ext_sel;
  logic [11:0] ext_instr;
  logic [3:0]  imem_addr;
  logic [11:0] imem_data;
  logic [11:0] instr_out;
  logic        instr_valid, instr_ready, exec_done;
  logic [3:0]  pc;
  logic        halted, wd_err;
  logic [7:0]  retired;

  logic [11:0] mem [16];
  int          checks = 0;
  int          failures = 0;
  logic        pend = 1'b0;
  int          issues;
  int          cnt;
  logic [3:0]  prev_pc;

  always #5 clk = ~clk;
  assign imem_data = mem[imem_addr];

  instr_sequencer #(.IW(12), .AW(4), .DONE_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .step_btn(step_btn), .run_en(run_en),
    .ext_sel(ext_sel), .ext_instr(ext_instr), .imem_addr(imem_addr),
    .imem_data(imem_data), .instr_out(instr_out), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .exec_done(exec_done), .pc(pc), .halted(halted),
    .wd_err(wd_err), .retired(retired)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    step_btn = 1'b0; run_en = 1'b0; ext_sel = 1'b0; ext_instr = 12'h000;
    instr_ready = 1'b1; exec_done = 1'b0; pend = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    tick();
    reset = 1'b1;
    tick();
  endtask

  // controller model: accept immediately, pulse done one cycle after the handshake
  task automatic serve();
    exec_done = pend;
    pend = instr_valid && instr_ready;
    tick();
  endtask

  task automatic pulse_step();
    step_btn = 1'b1;
    tick();
    step_btn = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 12'h035;
    @(negedge clk);

    // reset held with random inputs
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step_btn = 1'($urandom); run_en = 1'($urandom); ext_sel = 1'($urandom);
      ext_instr = 12'($urandom); instr_ready = 1'($urandom); exec_done = 1'($urandom);
      tick();
    end
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_wd", 32'(wd_err), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_instr", 32'(instr_out), 32'd0);
    clear_inputs();
    reset = 1'b1;
    tick();
    chk("rel_valid", 32'(instr_valid), 32'd0);
    chk("rel_pc", 32'(imem_addr), 32'd0);

    // single step
    mem[0] = 12'h035; mem[1] = 12'h1AB;
    pulse_step();
    chk("ss_lat1_valid", 32'(instr_valid), 32'd0);
    tick();
    chk("ss_valid", 32'(instr_valid), 32'd1);
    chk("ss_instr", 32'(instr_out), 32'h035);
    tick();
    chk("ss_hs_valid", 32'(instr_valid), 32'd0);
    tick(); tick();
    exec_done = 1'b1; tick(); exec_done = 1'b0;
    chk("ss_pc", 32'(pc), 32'd1);
    chk("ss_retired", 32'(retired), 32'd1);
    tick();
    chk("ss_idle_valid", 32'(instr_valid), 32'd0);
    pulse_step();
    tick();
    chk("ss2_valid", 32'(instr_valid), 32'd1);
    chk("ss2_instr", 32'(instr_out), 32'h1AB);
    tick();
    exec_done = 1'b1; tick(); exec_done = 1'b0;
    chk("ss2_pc", 32'(pc), 32'd2);
    exec_done = 1'b1; tick(); exec_done = 1'b0;
    chk("idle_done_ignored", 32'(retired), 32'd2);

    // free run to halt opcode
    mem[0] = 12'hA53; mem[1] = 12'h400; mem[2] = 12'hC11; mem[3] = 12'hE00;
    do_reset();
    run_en = 1'b1;
    issues = 0;
    for (int i = 0; i < 100 && !halted; i++) begin
      if (instr_valid && instr_ready) issues++;
      serve();
    end
    exec_done = 1'b0; pend = 1'b0;
    chk("fr_halted", 32'(halted), 32'd1);
    chk("fr_pc", 32'(pc), 32'd3);
    chk("fr_retired", 32'(retired), 32'd3);
    chk("fr_issues", 32'(issues), 32'd2);
    pulse_step();
    chk("fr_step_run_ignored", 32'(halted), 32'd1);
    run_en = 1'b0;
    pulse_step();
    chk("fr_restart_pc", 32'(pc), 32'd0);
    chk("fr_restart_halted", 32'(halted), 32'd0);

    // backpressure
    mem[0] = 12'h035;
    do_reset();
    instr_ready = 1'b0;
    pulse_step();
    tick();
    chk("bp_valid", 32'(instr_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      ext_sel = 1'($urandom); ext_instr = 12'($urandom);
      tick();
      chk("bp_hold_valid", 32'(instr_valid), 32'd1);
      chk("bp_hold_instr", 32'(instr_out), 32'h035);
    end
    ext_sel = 1'b0;
    instr_ready = 1'b1;
    tick();
    chk("bp_drop_valid", 32'(instr_valid), 32'd0);
    tick();
    chk("bp_once_valid", 32'(instr_valid), 32'd0);
    exec_done = 1'b1; tick(); exec_done = 1'b0;
    chk("bp_pc", 32'(pc), 32'd1);
    chk("bp_retired", 32'(retired), 32'd1);

    // watchdog: 15 WAIT_DONE cycles without done
    do_reset();
    pulse_step();
    tick();
    tick();
    repeat (14) tick();
    chk("wd_not_yet", 32'(halted), 32'd0);
    tick();
    chk("wd_halted", 32'(halted), 32'd1);
    chk("wd_err", 32'(wd_err), 32'd1);
    chk("wd_pc", 32'(pc), 32'd0);
    chk("wd_retired", 32'(retired), 32'd0);
    pulse_step();
    chk("wd_clear_err", 32'(wd_err), 32'd0);
    chk("wd_clear_halted", 32'(halted), 32'd0);
    // done arriving on the 15th cycle wins
    pulse_step();
    tick();
    tick();
    repeat (14) tick();
    exec_done = 1'b1; tick(); exec_done = 1'b0;
    chk("wd_edge_err", 32'(wd_err), 32'd0);
    chk("wd_edge_halted", 32'(halted), 32'd0);
    chk("wd_edge_pc", 32'(pc), 32'd1);
    chk("wd_edge_retired", 32'(retired), 32'd1);

    // external instruction path
    do_reset();
    ext_sel = 1'b1; ext_instr = 12'h107;
    pulse_step();
    chk("ext_valid", 32'(instr_valid), 32'd1);
    chk("ext_instr", 32'(instr_out), 32'h107);
    ext_sel = 1'b0; ext_instr = 12'hFFF;
    tick();
    exec_done = 1'b1; tick(); exec_done = 1'b0;
    chk("ext_pc", 32'(pc), 32'd0);
    chk("ext_retired", 32'(retired), 32'd1);

    // free run through pc wrap and retired saturation
    for (int i = 0; i < 16; i++) mem[i] = (i % 2 == 0) ? 12'h035 : 12'h400;
    do_reset();
    run_en = 1'b1;
    cnt = 0;
    prev_pc = pc;
    for (int i = 0; i < 5000 && cnt < 300; i++) begin
      serve();
      if (pc != prev_pc) begin
        cnt++;
        prev_pc = pc;
        if (cnt == 16) begin
          chk("wrap_pc", 32'(pc), 32'd0);
          chk("wrap_retired", 32'(retired), 32'd16);
        end
        if (cnt == 256) chk("sat_256", 32'(retired), 32'd255);
        if (cnt == 300) begin
          chk("run300_pc", 32'(pc), 32'd12);
          chk("run300_retired", 32'(retired), 32'd255);
          chk("run300_halted", 32'(halted), 32'd0);
        end
      end
    end
    chk("run300_budget", 32'(cnt), 32'd300);

    // asynchronous reset mid-run
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_pc", 32'(pc), 32'd0);
    chk("async_rst_retired", 32'(retired), 32'd0);
    clear_inputs();
    @(negedge clk);
    reset = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
